bcpu_flags_cond_unit: RTL and testbench
=======================================

// Module: bcpu_flags_cond_unit
// PURPOSE
//  Per-thread {V,S,Z,C} flag register file for the barrel core, with pipelined condition evaluation.
//  Sits between ALU writeback (masked flag updates) and the jump/conditional-exec decision in the fetch/decode stage.
//  Generalises the flag/condition path to THREAD_COUNT threads, adds partial-update masks and write-to-eval bypass.
//  Adds a configurable 1- or 2-cycle result latency.
// PARAMETERS
//  THREAD_COUNT     4   number of barrel threads (power of 2, >=2)
//  THREAD_ID_WIDTH  2   $clog2(THREAD_COUNT); derived localparam, not overridable
//  LATENCY          1   EVAL_* to RESULT_* latency in CE-qualified cycles; legal values 1 or 2
//  BYPASS           1   1: an eval of the thread being written in the same cycle sees the new flags; 0: sees old flags
// PORTS
//  CLK             in   1    clock, rising edge
//  RESET_N         in   1    asynchronous active-low reset
//  CE              in   1    clock enable; 0 freezes all state
//  WR_EN           in   1    flag update request
//  WR_THREAD       in   TIW  thread whose flags are updated
//  WR_MASK         in   4    per-flag write enable, bit order {V,S,Z,C}
//  WR_FLAGS        in   4    new flag values {V,S,Z,C}
//  EVAL_EN         in   1    condition evaluation request
//  EVAL_THREAD     in   TIW  thread to evaluate
//  EVAL_COND       in   4    condition code; 0000 = unconditional
//  RESULT_VALID    out  1    result strobe, LATENCY cycles after EVAL_EN
//  RESULT_THREAD   out  TIW  EVAL_THREAD echoed
//  RESULT_FLAGS    out  4    flags used for the evaluation
//  COND_RESULT     out  1    1 = condition true
// BEHAVIOUR
//  - Reset (async assert, sync release): all flag regs = 4'b0000; RESULT_VALID/THREAD/FLAGS/COND_RESULT = 0; pipe stages cleared.
//  - Reset mid-operation discards in-flight evals; no RESULT_VALID for them after release.
//  - Update (CE=1, WR_EN=1): flags[WR_THREAD] <= (flags & ~WR_MASK) | (WR_FLAGS & WR_MASK). WR_MASK=0 is a no-op.
//  - Read value: f = flags[EVAL_THREAD].
//    If BYPASS=1 and WR_EN and WR_THREAD==EVAL_THREAD, f = the merged value being written this cycle.
//  - Condition table on f (V=f[3], S=f[2], Z=f[1], C=f[0]):
//    0 1 | 1 ~C | 2 ~Z | 3 Z | 4 ~S | 5 S | 6 ~V | 7 V
//    8 A ~C&~Z | 9 AE ~C | 10 B C | 11 BE C|Z
//    12 L V^S | 13 LE (V^S)|Z | 14 G ~(V^S)&~Z | 15 GE ~(V^S)
//  - Latency 1: stage-1 regs capture {EVAL_EN, EVAL_THREAD, f, table(f)} and drive the outputs directly.
//  - Latency 2: stage 1 captures {EN, THREAD, COND, f}; the table is evaluated from stage 1; stage 2 drives the outputs.
//  - Every stage follows its input each CE=1 cycle. RESULT_VALID=0 is a bubble; other outputs are don't-care but must stay deterministic.
//  - CE=0: no flag update, pipe holds, outputs hold (a held RESULT_VALID=1 is not a new result).
//  - Evals with no write to the same thread never interfere; one eval per cycle, fully pipelined, no backpressure.
//  - LATENCY=2 hazard: a write landing after the eval is sampled is not seen (the eval uses the flags captured at stage 1).
//  - Out-of-range thread ids are impossible: THREAD_COUNT is a power of 2.
// STRUCTURE
//  - bcpu_defs package: FLAG_V/S/Z/C bit indices, COND_* 4-bit codes (table above), typedef flags_t = logic[3:0].
//  - bcpu_defs package also holds typedef cond_t = logic[3:0].
//  - Sub-module bcpu_cond_lut: pure combinational table(f, cond) -> bit, instantiated once per eval stage.
//  - Flag file: THREAD_COUNT x flags_t in flops (not RAM), to allow same-cycle bypass and async reset.
// TESTING
//  1. Reset: pulse RESET_N low mid-run -> all outputs 0 immediately. Eval T2 cond 3 (Z) -> 0; cond 0 -> 1.
//  2. Masked write: T1 WR_FLAGS=1111 mask=1111, then WR_FLAGS=0000 mask=0010.
//     Eval T1 cond 2 -> 1; RESULT_FLAGS=1101.
//  3. Bypass: same cycle WR T3 flags=0001 mask=1111 and eval T3 cond 10 (B).
//     BYPASS=1 -> COND_RESULT=1; BYPASS=0 -> 0.
//  4. Table sweep: all 16 flag values x 16 conds on T0 vs a reference function.
//     Check e.g. f=1000 (V only): L=1, GE=0; f=0000: A=1, AE=1.
//  5. Pipelining/CE: evals T0..T3 back-to-back with CE=1,0,1,1,1 -> results appear in order with THREAD 0..3.
//     Observed latency = LATENCY+1 cycles for the eval straddling CE=0; no lost or duplicated RESULT_VALID.
//  6. Isolation: write T0 flags=0110 while evaluating T1 the same cycle -> T1 result uses T1 flags, unaffected by the T0 write.

Source files
------------

// File: rtl/bcpu_defs_pkg.sv
// Shared definitions for the barrel-core flag/condition path: flag bit
// positions, condition codes and the masked flag-merge helper.
package bcpu_defs;

  typedef logic [3:0] flags_t;
  typedef logic [3:0] cond_t;

  // Flag bit positions inside flags_t, ordered {V,S,Z,C}.
  localparam int FLAG_V = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Condition codes.
  localparam cond_t COND_AL = 4'd0;   // always
  localparam cond_t COND_NC = 4'd1;   // ~C
  localparam cond_t COND_NZ = 4'd2;   // ~Z
  localparam cond_t COND_ZS = 4'd3;   // Z
  localparam cond_t COND_NS = 4'd4;   // ~S
  localparam cond_t COND_SS = 4'd5;   // S
  localparam cond_t COND_NV = 4'd6;   // ~V
  localparam cond_t COND_VS = 4'd7;   // V
  localparam cond_t COND_A  = 4'd8;   // unsigned above
  localparam cond_t COND_AE = 4'd9;   // unsigned above or equal
  localparam cond_t COND_B  = 4'd10;  // unsigned below
  localparam cond_t COND_BE = 4'd11;  // unsigned below or equal
  localparam cond_t COND_L  = 4'd12;  // signed less
  localparam cond_t COND_LE = 4'd13;  // signed less or equal
  localparam cond_t COND_G  = 4'd14;  // signed greater
  localparam cond_t COND_GE = 4'd15;  // signed greater or equal

  // Replace only the flags selected by mask; the rest keep their old value.
  function automatic flags_t merge_flags(input flags_t old_flags,
                                         input flags_t mask,
                                         input flags_t new_flags);
    return (old_flags & ~mask) | (new_flags & mask);
  endfunction

endpackage

// File: rtl/bcpu_cond_lut.sv
// Pure combinational condition table: decides whether a condition code
// holds for a given {V,S,Z,C} flag vector.
module bcpu_cond_lut
  import bcpu_defs::*;
(
  input  flags_t flags,
  input  cond_t  cond,
  output logic   result
);

  logic v, s, z, c;

  assign v = flags[FLAG_V];
  assign s = flags[FLAG_S];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];

  // Decode the condition code against the current flags.
  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = 1'b0;
    case (cond)
      COND_AL: result = 1'b1;
      COND_NC: result = ~c;
      COND_NZ: result = ~z;
      COND_ZS: result = z;
      COND_NS: result = ~s;
      COND_SS: result = s;
      COND_NV: result = ~v;
      COND_VS: result = v;
      COND_A:  result = ~c & ~z;
      COND_AE: result = ~c;
      COND_B:  result = c;
      COND_BE: result = c | z;
      COND_L:  result = v ^ s;
      COND_LE: result = (v ^ s) | z;
      COND_G:  result = ~(v ^ s) & ~z;
      COND_GE: result = ~(v ^ s);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/bcpu_flags_cond_unit.sv
// Per-thread {V,S,Z,C} flag register file with masked updates, optional
// write-to-eval bypass and a 1- or 2-stage condition evaluation pipe.
module bcpu_flags_cond_unit
  import bcpu_defs::*;
#(
  parameter  int THREAD_COUNT    = 4,
  parameter  int LATENCY         = 1,
  parameter  bit BYPASS          = 1'b1,
  localparam int THREAD_ID_WIDTH = $clog2(THREAD_COUNT)
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       CE,
  input  logic                       WR_EN,
  input  logic [THREAD_ID_WIDTH-1:0] WR_THREAD,
  input  flags_t                     WR_MASK,
  input  flags_t                     WR_FLAGS,
  input  logic                       EVAL_EN,
  input  logic [THREAD_ID_WIDTH-1:0] EVAL_THREAD,
  input  cond_t                      EVAL_COND,
  output logic                       RESULT_VALID,
  output logic [THREAD_ID_WIDTH-1:0] RESULT_THREAD,
  output flags_t                     RESULT_FLAGS,
  output logic                       COND_RESULT
);

  typedef logic [THREAD_ID_WIDTH-1:0] tid_t;

  flags_t flag_file [THREAD_COUNT];
  flags_t wr_merged;
  flags_t eval_flags;

  assign wr_merged = merge_flags(flag_file[WR_THREAD], WR_MASK, WR_FLAGS);

  // Flag file update; held when CE is low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the flag file is flops, not RAM, so every entry is cleared on reset.
      for (int i = 0; i < THREAD_COUNT; i++) begin
        flag_file[i] <= '0;
      end
    end else if (CE && WR_EN) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      flag_file[WR_THREAD] <= wr_merged;
    end
  end

  // Select the flags seen by the eval, forwarding a same-thread write if enabled.
  always_comb begin
    eval_flags = flag_file[EVAL_THREAD];
    if (BYPASS && WR_EN && (WR_THREAD == EVAL_THREAD)) begin
      eval_flags = wr_merged;
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      logic   eval_result;
      logic   s1_valid;
      tid_t   s1_thread;
      flags_t s1_flags;
      logic   s1_result;

      bcpu_cond_lut u_cond_lut (
        .flags  (eval_flags),
        .cond   (EVAL_COND),
        .result (eval_result)
      );

      // Single stage: capture the evaluated condition and drive the outputs.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          s1_valid  <= 1'b0;
          s1_thread <= '0;
          s1_flags  <= '0;
          s1_result <= 1'b0;
        end else if (CE) begin
          s1_valid  <= EVAL_EN;
          s1_thread <= EVAL_THREAD;
          s1_flags  <= eval_flags;
          s1_result <= eval_result;
        end
      end

      assign RESULT_VALID  = s1_valid;
      assign RESULT_THREAD = s1_thread;
      assign RESULT_FLAGS  = s1_flags;
      assign COND_RESULT   = s1_result;
    end else begin : g_lat2
      logic   s1_valid;
      tid_t   s1_thread;
      cond_t  s1_cond;
      flags_t s1_flags;
      logic   s1_result;
      logic   s2_valid;
      tid_t   s2_thread;
      flags_t s2_flags;
      logic   s2_result;

      bcpu_cond_lut u_cond_lut (
        .flags  (s1_flags),
        .cond   (s1_cond),
        .result (s1_result)
      );

      // Stage 1: capture the request and the flags it observes.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          s1_valid  <= 1'b0;
          s1_thread <= '0;
          s1_cond   <= '0;
          s1_flags  <= '0;
        end else if (CE) begin
          s1_valid  <= EVAL_EN;
          s1_thread <= EVAL_THREAD;
          s1_cond   <= EVAL_COND;
          s1_flags  <= eval_flags;
        end
      end

      // Stage 2: register the table result evaluated from stage 1.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          s2_valid  <= 1'b0;
          s2_thread <= '0;
          s2_flags  <= '0;
          s2_result <= 1'b0;
        end else if (CE) begin
          s2_valid  <= s1_valid;
          s2_thread <= s1_thread;
          s2_flags  <= s1_flags;
          s2_result <= s1_result;
        end
      end

      assign RESULT_VALID  = s2_valid;
      assign RESULT_THREAD = s2_thread;
      assign RESULT_FLAGS  = s2_flags;
      assign COND_RESULT   = s2_result;
    end
  endgenerate

endmodule

// File: tb/tb_bcpu_flags_cond_unit.sv
// Scoreboard bench: two instances (LATENCY=1/BYPASS=1 and LATENCY=2/BYPASS=0)
// share stimulus; a flag model predicts each result and its arrival edge.
module tb_bcpu_flags_cond_unit;

  logic       CLK;
  logic       RESET_N;
  logic       CE;
  logic       WR_EN;
  logic [1:0] WR_THREAD;
  logic [3:0] WR_MASK;
  logic [3:0] WR_FLAGS;
  logic       EVAL_EN;
  logic [1:0] EVAL_THREAD;
  logic [3:0] EVAL_COND;

  logic       a_valid, b_valid;
  logic [1:0] a_thread, b_thread;
  logic [3:0] a_flags, b_flags;
  logic       a_cond, b_cond;

  typedef struct {
    int unsigned edge_no;
    logic [1:0]  thread;
    logic [3:0]  flags;
    logic        res;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [3:0]  model [4];
  int unsigned ce_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  bcpu_flags_cond_unit #(.THREAD_COUNT(4), .LATENCY(1), .BYPASS(1'b1)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .WR_EN(WR_EN), .WR_THREAD(WR_THREAD),
    .WR_MASK(WR_MASK), .WR_FLAGS(WR_FLAGS), .EVAL_EN(EVAL_EN),
    .EVAL_THREAD(EVAL_THREAD), .EVAL_COND(EVAL_COND), .RESULT_VALID(a_valid),
    .RESULT_THREAD(a_thread), .RESULT_FLAGS(a_flags), .COND_RESULT(a_cond)
  );

  bcpu_flags_cond_unit #(.THREAD_COUNT(4), .LATENCY(2), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .WR_EN(WR_EN), .WR_THREAD(WR_THREAD),
    .WR_MASK(WR_MASK), .WR_FLAGS(WR_FLAGS), .EVAL_EN(EVAL_EN),
    .EVAL_THREAD(EVAL_THREAD), .EVAL_COND(EVAL_COND), .RESULT_VALID(b_valid),
    .RESULT_THREAD(b_thread), .RESULT_FLAGS(b_flags), .COND_RESULT(b_cond)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference condition table, {V,S,Z,C}.
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
    logic v, s, z, cy;
    v = f[3]; s = f[2]; z = f[1]; cy = f[0];
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return !cy;
      4'd2:  return !z;
      4'd3:  return z;
      4'd4:  return !s;
      4'd5:  return s;
      4'd6:  return !v;
      4'd7:  return v;
      4'd8:  return !cy && !z;
      4'd9:  return !cy;
      4'd10: return cy;
      4'd11: return cy || z;
      4'd12: return v != s;
      4'd13: return (v != s) || z;
      4'd14: return (v == s) && !z;
      default: return v == s;
    endcase
  endfunction

  // Drive one cycle of stimulus and push the predicted results.
  task automatic step(input logic ce, input logic wen, input logic [1:0] wt,
                      input logic [3:0] wm, input logic [3:0] wf, input logic een,
                      input logic [1:0] et, input logic [3:0] ec);
    logic [3:0] merged, fa, fb;
    exp_t e;
    @(negedge CLK);
    CE = ce; WR_EN = wen; WR_THREAD = wt; WR_MASK = wm; WR_FLAGS = wf;
    EVAL_EN = een; EVAL_THREAD = et; EVAL_COND = ec;
    if (ce && RESET_N) begin
      merged = (model[wt] & ~wm) | (wf & wm);
      if (een) begin
        fa = (wen && wt == et) ? merged : model[et];
        fb = model[et];
        e.edge_no = ce_cnt + 1; e.thread = et; e.flags = fa; e.res = cond_ref(fa, ec);
        q_a.push_back(e);
        e.edge_no = ce_cnt + 2; e.flags = fb; e.res = cond_ref(fb, ec);
        q_b.push_back(e);
      end
      if (wen) model[wt] = merged;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic score(input int which, input logic v, input logic [1:0] th,
                       input logic [3:0] fl, input logic r);
    exp_t e;
    if (!v) return;
    if ((which == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
      check((which == 0) ? "a_spurious_valid" : "b_spurious_valid", 32'd1, 32'd0);
      return;
    end
    e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
    check((which == 0) ? "a_edge" : "b_edge", ce_cnt, e.edge_no);
    check((which == 0) ? "a_thread" : "b_thread", 32'(th), 32'(e.thread));
    check((which == 0) ? "a_flags" : "b_flags", 32'(fl), 32'(e.flags));
    check((which == 0) ? "a_cond" : "b_cond", 32'(r), 32'(e.res));
  endtask

  // Count CE-qualified edges and score any new result just after each one.
  always @(posedge CLK) begin
    if (RESET_N && CE) begin
      ce_cnt++;
      #1;
      score(0, a_valid, a_thread, a_flags, a_cond);
      score(1, b_valid, b_thread, b_flags, b_cond);
    end
  end

  task automatic check_outputs_zero();
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_thread", 32'(a_thread), 32'd0);
    check("rst_a_flags", 32'(a_flags), 32'd0);
    check("rst_a_cond", 32'(a_cond), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_b_thread", 32'(b_thread), 32'd0);
    check("rst_b_flags", 32'(b_flags), 32'd0);
    check("rst_b_cond", 32'(b_cond), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; CE = 1'b0; WR_EN = 1'b0; WR_THREAD = '0; WR_MASK = '0;
    WR_FLAGS = '0; EVAL_EN = 1'b0; EVAL_THREAD = '0; EVAL_COND = '0;
    for (int i = 0; i < 4; i++) model[i] = 4'd0;
    #1;
    check_outputs_zero();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // 1. Reset mid-run with an eval in flight, then evaluate T2.
    step(1'b1, 1'b1, 2'd2, 4'b1111, 4'b1111, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd2, 4'd3);
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check_outputs_zero();
    q_a.delete(); q_b.delete();
    for (int i = 0; i < 4; i++) model[i] = 4'd0;
    CE = 1'b0; EVAL_EN = 1'b0; WR_EN = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd2, 4'd3);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd2, 4'd0);
    repeat (3) idle();

    // 2. Masked write on T1.
    step(1'b1, 1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd1, 4'd2);
    step(1'b1, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'd3);

    // 3. Same-cycle write and eval of T3 (bypass vs no bypass).
    step(1'b1, 1'b1, 2'd3, 4'b1111, 4'b0001, 1'b1, 2'd3, 4'd10);
    repeat (3) idle();

    // 4. Table sweep on T0.
    for (int f = 0; f < 16; f++) begin
      step(1'b1, 1'b1, 2'd0, 4'b1111, 4'(f), 1'b0, 2'd0, 4'd0);
      for (int c = 0; c < 16; c++) begin
        step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd0, 4'(c));
      end
    end
    repeat (3) idle();

    // 5. Back-to-back evals T0..T3 with CE=1,0,1,1,1.
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd0, 4'd0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd1, 4'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd1, 4'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd2, 4'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd3, 4'd0);
    repeat (3) idle();

    // 6. Write T0 while evaluating T1.
    step(1'b1, 1'b1, 2'd1, 4'b1111, 4'b1001, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b1, 2'd0, 4'b1111, 4'b0110, 1'b1, 2'd1, 4'd12);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd0, 4'd3);
    repeat (3) idle();

    // Random traffic with occasional CE stalls.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    repeat (5) idle();

    check("a_drained", q_a.size(), 32'd0);
    check("b_drained", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
